// File: rtl/axis_tx_gearbox.sv
// axis_tx_gearbox: splits full-width AXIS words into LSB-first slices
// for the serializer and counts input underruns.
module axis_tx_gearbox #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  tdata_in,
  input  logic                 tvalid_in,
  output logic                 tready_in,
  output logic [OUT_WIDTH-1:0] tdata_out,
  output logic                 tvalid_out,
  input  logic                 tready_out,
  input  logic                 clear_counters,
  output logic                 underrun,
  output logic [15:0]          underrun_count
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(RATIO - 1);

  generate
    if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("axis_tx_gearbox: IN_WIDTH must be >= 2x and a multiple of OUT_WIDTH");
    end
  endgenerate

  logic [IN_WIDTH-1:0] word_reg;
  logic [IDXW-1:0]     idx;
  logic                loaded;
  logic [15:0]         count_q;
  logic                last_accept;
  logic                load;
  logic                under_ev;

  // Handshake decode: the final slice leaving frees the word register.
  always_comb begin
    last_accept = loaded && tready_out && (idx == LAST);
    tready_in   = !rst && (!loaded || last_accept);
    load        = tvalid_in && tready_in;
    under_ev    = last_accept && !tvalid_in;
  end

  assign tdata_out      = word_reg[int'(idx) * OUT_WIDTH +: OUT_WIDTH];
  assign tvalid_out     = loaded;
  assign underrun_count = count_q;

  // Word register, slice index and loaded flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= '0;
      idx      <= '0;
      loaded   <= 1'b0;
    end else if (load) begin
      word_reg <= tdata_in;
      idx      <= '0;
      loaded   <= 1'b1;
    end else if (last_accept) begin
      idx      <= '0;
      loaded   <= 1'b0;
    end else if (loaded && tready_out) begin
      idx      <= idx + 1'b1;
    end
  end

  // Underrun pulse and saturating event counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
      count_q  <= '0;
    end else begin
      underrun <= under_ev;
      if (clear_counters)
        count_q <= '0;
      else if (under_ev && count_q != 16'hFFFF)
        count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_tx_gearbox.sv
// tb_axis_tx_gearbox: directed bench for the width-down gearbox.
// Inputs change and outputs are sampled around the falling edge.
module tb_axis_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata_in;
  logic        tvalid_in;
  logic        tready_in;
  logic [7:0]  tdata_out;
  logic        tvalid_out;
  logic        tready_out;
  logic        clear_counters;
  logic        underrun;
  logic [15:0] underrun_count;

  int vectors = 0;
  int miscompares = 0;

  axis_tx_gearbox #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .tdata_in(tdata_in),
    .tvalid_in(tvalid_in),
    .tready_in(tready_in),
    .tdata_out(tdata_out),
    .tvalid_out(tvalid_out),
    .tready_out(tready_out),
    .clear_counters(clear_counters),
    .underrun(underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    tvalid_in = 1'b0;
    tdata_in = 32'h0;
    tready_out = 1'b0;
    clear_counters = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (tvalid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tvalid_out got %b want 0", tvalid_out);
    end
    vectors++;
    if (tready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tready_in got %b want 0", tready_in);
    end
    vectors++;
    if (tdata_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tdata_out got %h want 00", tdata_out);
    end
    vectors++;
    if (underrun !== 1'b0 || underrun_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_underrun got %b/%h want 0/0000",
               underrun, underrun_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    tready_out = 1'b1;
    tvalid_in = 1'b1;
    tdata_in = 32'h44332211;
    #1;
    vectors++;
    if (tready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle_ready got %b want 1", tready_in);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tvalid_in = 1'b0;
      #1;
      vectors++;
      if (tdata_out !== exp[i] || tvalid_out !== 1'b1 || underrun !== 1'b0) begin
        miscompares++;
        $display("FAIL single_slice%0d got %h/%b/%b want %h/1/0",
                 i, tdata_out, tvalid_out, underrun, exp[i]);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (tvalid_out !== 1'b0 || underrun !== 1'b1 || underrun_count !== 16'd1) begin
      miscompares++;
      $display("FAIL single_underrun got v=%b u=%b c=%h want 0/1/0001",
               tvalid_out, underrun, underrun_count);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse_width got %b want 0", underrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3,
                            8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic       rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    clear_counters = 1'b1;
    @(negedge clk);
    clear_counters = 1'b0;
    tvalid_in = 1'b1;
    tdata_in = 32'hA3A2A1A0;
    #1;
    vectors++;
    if (underrun_count !== 16'h0) begin
      miscompares++;
      $display("FAIL b2b_clear got %h want 0000", underrun_count);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tdata_in = 32'hB3B2B1B0;
      tvalid_in = (i != 7);
      #1;
      vectors++;
      if (tdata_out !== exp[i] || tvalid_out !== 1'b1 ||
          tready_in !== rdy[i] || underrun !== 1'b0 ||
          underrun_count !== 16'h0) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d got d=%h v=%b r=%b u=%b c=%h want d=%h v=1 r=%b u=0 c=0000",
                 i, tdata_out, tvalid_out, tready_in, underrun,
                 underrun_count, exp[i], rdy[i]);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (tvalid_out !== 1'b0 || underrun !== 1'b1 || underrun_count !== 16'd1) begin
      miscompares++;
      $display("FAIL b2b_stop got v=%b u=%b c=%h want 0/1/0001",
               tvalid_out, underrun, underrun_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3] = '{8'h22, 8'h33, 8'h44};
    @(negedge clk);
    tvalid_in = 1'b1;
    tdata_in = 32'h44332211;
    tready_out = 1'b1;
    @(negedge clk);
    tvalid_in = 1'b0;
    #1;
    vectors++;
    if (tdata_out !== 8'h11 || tvalid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first got %h/%b want 11/1", tdata_out, tvalid_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tready_out = 1'b0;
      #1;
      vectors++;
      if (tdata_out !== 8'h22 || tvalid_out !== 1'b1 ||
          tready_in !== 1'b0 || underrun !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall%0d got d=%h v=%b r=%b u=%b want 22/1/0/0",
                 k, tdata_out, tvalid_out, tready_in, underrun);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tready_out = 1'b1;
      #1;
      vectors++;
      if (tdata_out !== exp[i] || tvalid_out !== 1'b1 ||
          tready_in !== (i == 2)) begin
        miscompares++;
        $display("FAIL bp_resume%0d got d=%h v=%b r=%b want %h/1/%b",
                 i, tdata_out, tvalid_out, tready_in, exp[i], i == 2);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (underrun !== 1'b1 || underrun_count !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_underrun got u=%b c=%h want 1/0002",
               underrun, underrun_count);
    end
  endtask

  task automatic test_clear_coincident();
    logic [7:0] exp [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
    @(negedge clk);
    tvalid_in = 1'b1;
    tdata_in = 32'h87654321;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tvalid_in = 1'b0;
      clear_counters = (i == 3);
      #1;
      vectors++;
      if (tdata_out !== exp[i]) begin
        miscompares++;
        $display("FAIL clr_slice%0d got %h want %h", i, tdata_out, exp[i]);
      end
    end
    @(negedge clk);
    clear_counters = 1'b0;
    #1;
    vectors++;
    if (underrun !== 1'b1 || underrun_count !== 16'h0) begin
      miscompares++;
      $display("FAIL clr_vs_underrun got u=%b c=%h want 1/0000",
               underrun, underrun_count);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp [4] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    @(negedge clk);
    force dut.count_q = 16'hFFFD;
    #1;
    release dut.count_q;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      tvalid_in = 1'b1;
      tdata_in = 32'h0F0E0D0C;
      repeat (4) begin
        @(negedge clk);
        tvalid_in = 1'b0;
      end
      @(negedge clk);
      #1;
      vectors++;
      if (underrun !== 1'b1 || underrun_count !== exp[r]) begin
        miscompares++;
        $display("FAIL sat_round%0d got u=%b c=%h want 1/%h",
                 r, underrun, underrun_count, exp[r]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    tvalid_in = 1'b1;
    tdata_in = 32'h44332211;
    tready_out = 1'b1;
    @(negedge clk);
    tvalid_in = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (tdata_out !== 8'h22) begin
      miscompares++;
      $display("FAIL rmw_pre got %h want 22", tdata_out);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_ready_in_rst got %b want 0", tready_in);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (tvalid_out !== 1'b0 || underrun !== 1'b0 || underrun_count !== 16'h0) begin
      miscompares++;
      $display("FAIL rmw_after_rst got v=%b u=%b c=%h want 0/0/0000",
               tvalid_out, underrun, underrun_count);
    end
    tvalid_in = 1'b1;
    tdata_in = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tvalid_in = 1'b0;
      #1;
      vectors++;
      if (tdata_out !== exp[i] || tvalid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL rmw_slice%0d got %h/%b want %h/1",
                 i, tdata_out, tvalid_out, exp[i]);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (underrun !== 1'b1 || underrun_count !== 16'd1) begin
      miscompares++;
      $display("FAIL rmw_underrun got u=%b c=%h want 1/0001",
               underrun, underrun_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_clear_coincident();
    test_saturation();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
